// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Purpose: multi-cycle 32x32 multiply / divide unit that owns the HI/LO pair.
// Multiplication is shift-add, one multiplier bit per cycle, LSB first.
// Division is restoring, one quotient bit per cycle, MSB first. Signed
// operations work on magnitudes and apply the result signs in a final FIX
// cycle. Every operation takes 33 cycles from start to commit.
//
// Ports:
//   clk        in   1   system clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   issue pulse from the execute stage
//   op         in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in1        in  32   multiplicand / dividend
//   in2        in  32   multiplier / divisor
//   mthi       in   1   write wdata into HI (IDLE only)
//   mtlo       in   1   write wdata into LO (IDLE only)
//   wdata      in  32   MTHI/MTLO data
//   hi         out 32   HI register (remainder / product[63:32])
//   lo         out 32   LO register (quotient / product[31:0])
//   busy       out  1   operation in flight, HI/LO not yet valid
//   done       out  1   one-cycle pulse, HI/LO just committed
//   dbg_state  out  2   current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start behaves as a valid with busy acting as an inverted ready.
// A start is accepted only on an edge where busy is low; starts seen while
// busy is high are dropped, as are mthi/mtlo. When start and mthi/mtlo are
// both high in IDLE, start is taken and the register writes are discarded.
// -----------------------------------------------------------------------------
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [4:0]  r_cnt;
  logic        r_is_div;
  logic        r_neg_lo;   // negate product / quotient
  logic        r_neg_hi;   // negate remainder (dividend sign)
  logic        r_div0;
  logic [31:0] r_raw1;     // unmodified in1, returned in HI on divide by zero
  logic [31:0] r_dvsr;     // multiplicand magnitude or divisor magnitude
  logic [63:0] r_acc;      // mult: {partial product, remaining multiplier}
                           // div:  [31:0] dividend bits shifting out, quotient bits shifting in
  logic [31:0] r_rem;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;

  // Operand magnitudes and signs, only meaningful on the accept cycle.
  logic        w_signed;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;

  assign w_signed = ~op[0];
  assign w_a_neg  = w_signed & in1[31];
  assign w_b_neg  = w_signed & in2[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - in1) : in1;
  assign w_b_mag  = w_b_neg ? (32'd0 - in2) : in2;

  // Shift-add step: add the multiplicand into the upper half when the
  // current multiplier LSB is set, then shift the whole accumulator right.
  logic [32:0] w_sum;
  logic [63:0] w_acc_mul;

  assign w_sum     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_dvsr} : 33'd0);
  assign w_acc_mul = {w_sum, r_acc[31:1]};

  // Restoring division step on a 33-bit partial remainder. If the shifted
  // remainder is at least the divisor, the difference is below the divisor
  // and therefore fits back into 32 bits, so a 32-bit subtract is exact.
  logic [32:0] w_shift;
  logic        w_qbit;
  logic [31:0] w_rem_next;

  assign w_shift    = {r_rem, r_acc[31]};
  assign w_qbit     = w_shift[32] | (w_shift[31:0] >= r_dvsr);
  assign w_rem_next = w_shift[31:0] - (w_qbit ? r_dvsr : 32'd0);

  // Final sign correction.
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem_s;

  assign w_prod  = r_neg_lo ? (64'd0 - r_acc) : r_acc;
  assign w_quo   = r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_rem_s = r_neg_hi ? (32'd0 - r_rem) : r_rem;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == 5'd0) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= 5'd0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_div0   <= 1'b0;
      r_raw1   <= 32'd0;
      r_dvsr   <= 32'd0;
      r_acc    <= 64'd0;
      r_rem    <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= 5'd31;
            r_is_div <= op[1];
            r_neg_lo <= w_a_neg ^ w_b_neg;
            r_neg_hi <= w_a_neg;
            r_div0   <= op[1] & (in2 == 32'd0);
            r_raw1   <= in1;
            r_rem    <= 32'd0;
            r_busy   <= 1'b1;
            if (op[1]) begin
              r_dvsr <= w_b_mag;
              r_acc  <= {32'd0, w_a_mag};
            end else begin
              r_dvsr <= w_a_mag;
              r_acc  <= {32'd0, w_b_mag};
            end
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
          if (r_is_div) begin
            r_rem        <= w_rem_next;
            r_acc[31:0]  <= {r_acc[30:0], w_qbit};
          end else begin
            r_acc <= w_acc_mul;
          end
        end
        S_FIX: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          if (!r_is_div) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (r_div0) begin
            r_hi <= r_raw1;
            r_lo <= 32'hFFFF_FFFF;
          end else begin
            r_hi <= w_rem_s;
            r_lo <= w_quo;
          end
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an
// arithmetic reference model (64-bit products, truncating division).
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic [1:0]  dbg_state;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
  endtask

  // Reference: {HI, LO} for one operation.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] vq, vr, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'd2) begin
          q = sa / sb;
          r = sa % sb;
          vq = 64'(q);
          vr = 64'(r);
          res = {vr[31:0], vq[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
    endcase
    return res;
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one op and returns sampled in the done cycle. poke_at >= 0 pulses a
  // stray start plus mtlo at that busy cycle; both must be ignored.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke_at);
    int          n;
    int          busy_cnt;
    logic [63:0] e;
    exp_q.push_back(model(o, a, b));
    op = o; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!done && n < 40) begin
      if (busy) busy_cnt++;
      if (n == 0 || n == 20) begin
        check("hi_hold", {32'd0, hi}, {32'd0, m_hi});
        check("lo_hold", {32'd0, lo}, {32'd0, m_lo});
      end
      if (n == poke_at) begin
        start = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        op = 2'd0; in1 = $urandom; in2 = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0; mtlo = 1'b0;
      n++;
    end
    check("latency", 64'(n), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_at_done", {63'd0, busy}, 64'd0);
    e = exp_q.pop_front();
    check("hi", {32'd0, hi}, {32'd0, e[63:32]});
    check("lo", {32'd0, lo}, {32'd0, e[31:0]});
    m_hi = e[63:32];
    m_lo = e[31:0];
  endtask

  task automatic idle_write(input logic h, input logic l, input logic [31:0] v);
    mthi = h; mtlo = l; wdata = v;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (h) m_hi = v;
    if (l) m_lo = v;
    check("mt_hi", {32'd0, hi}, {32'd0, m_hi});
    check("mt_lo", {32'd0, lo}, {32'd0, m_lo});
  endtask

  task automatic quiet_cycles(input int k);
    int dcnt;
    dcnt = 0;
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("no_extra_done", 64'(dcnt), 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dcnt;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0; start = 1'b0; op = 2'd0; in1 = 32'd0; in2 = 32'd0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    do_op(2'd0, 32'hFFFF_FFF9, 32'd3, -1);
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    do_op(2'd1, 32'hFFFF_FFFF, 32'd2, -1);
    do_op(2'd3, 32'd100, 32'd7, -1);          // back-to-back from done cycle
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1);
    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    do_op(2'd2, 32'd5, 32'd0, 10);            // stray start + mtlo while busy
    quiet_cycles(40);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd0, -1);
    do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);

    idle_write(1'b1, 1'b0, 32'h1234_5678);
    idle_write(1'b0, 1'b1, 32'hCAFE_0001);
    idle_write(1'b1, 1'b1, 32'h0BAD_F00D);
    mtlo = 1'b1; wdata = 32'h5555_AAAA;       // dropped: start wins
    do_op(2'd1, 32'd9, 32'd9, -1);

    // Reset in the middle of an operation.
    op = 2'd0; in1 = 32'd6; in2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    do_op(2'd0, 32'd6, 32'd7, -1);

    // Randomized operations.
    for (int t = 0; t < 40; t++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 32)) : -1);
      if ($urandom_range(0, 1) == 1) begin
        idle_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
